fc_layer_mac: RTL and testbench

//  Sequential fully-connected layer; direct upstream producer of the ReLU stage's output_fc bus.
//  On a start pulse, latches an input activation vector and computes each output neuron as
//    sum(in[i]*W[o][i]) + bias[o]

---
 rtl/fc_layer_mac.sv | 162 ++++++++++++++++
 tb/tb_fc_layer_mac.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_mac.sv
// fc_layer_mac
//   Sequential fully-connected layer. A start request latches the activation
//   vector and biases, then one signed fixed-point MAC computes every output
//   neuron as sum(in[i]*W[o][i]) + bias[o]. Weights are read from an external
//   synchronous ROM (data arrives one cycle after the address). Results are
//   saturated to DATA_WIDTH, collected on one flat bus, and done pulses when
//   the whole bus is valid.
//
// Ports
//   clk          clock, all state changes on posedge
//   reset        synchronous active-high reset
//   en           start request, sampled only while idle
//   input_fc     activations, word i at [DATA_WIDTH*i +: DATA_WIDTH]
//   bias         per-neuron bias, word o at [DATA_WIDTH*o +: DATA_WIDTH]
//   weight_addr  registered ROM address, o*INPUT_NEURONS + i
//   weight_data  ROM data, valid one cycle after weight_addr
//   output_fc    results, word o at [DATA_WIDTH*o +: DATA_WIDTH]
//   busy         high from the cycle after start until done
//   done         one-cycle pulse, output_fc complete and stable
//
// state | meaning
// IDLE  | waiting for en; latches inputs on start
// ISSUE | address of neuron o's first weight on the ROM; acc <= bias
// MAC   | one product per cycle, INPUT_NEURONS cycles
// STORE | shift, saturate, write output word o
// DONE  | raise done, drop busy
module fc_layer_mac #(
  parameter int DATA_WIDTH     = 32,
  parameter int FRAC_BITS      = 16,
  parameter int INPUT_NEURONS  = 64,
  parameter int OUTPUT_NEURONS = 32,
  parameter int ADDR_WIDTH     = 11
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 en,
  input  logic [DATA_WIDTH*INPUT_NEURONS-1:0]  input_fc,
  input  logic [DATA_WIDTH*OUTPUT_NEURONS-1:0] bias,
  output logic [ADDR_WIDTH-1:0]                weight_addr,
  input  logic [DATA_WIDTH-1:0]                weight_data,
  output logic [DATA_WIDTH*OUTPUT_NEURONS-1:0] output_fc,
  output logic                                 busy,
  output logic                                 done
);

  localparam int ACC_W = 2*DATA_WIDTH + $clog2(INPUT_NEURONS);
  localparam int IW    = (INPUT_NEURONS  > 1) ? $clog2(INPUT_NEURONS)  : 1;
  localparam int OW    = (OUTPUT_NEURONS > 1) ? $clog2(OUTPUT_NEURONS) : 1;

  localparam logic [IW-1:0] I_LAST = IW'(INPUT_NEURONS - 1);
  localparam logic [OW-1:0] O_LAST = OW'(OUTPUT_NEURONS - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] MAC   = 3'd2;
  localparam logic [2:0] STORE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]                   state;
  logic signed [DATA_WIDTH-1:0] in_q   [INPUT_NEURONS];
  logic signed [DATA_WIDTH-1:0] bias_q [OUTPUT_NEURONS];
  logic signed [DATA_WIDTH-1:0] out_q  [OUTPUT_NEURONS];
  logic signed [ACC_W-1:0]      acc;
  logic [IW-1:0]                i_cnt;
  logic [OW-1:0]                o_cnt;

  logic signed [2*DATA_WIDTH-1:0] product;
  logic signed [ACC_W-1:0]        bias_ext;
  logic signed [ACC_W-1:0]        shifted;
  logic signed [DATA_WIDTH-1:0]   sat_word;

  assign product  = in_q[i_cnt] * $signed(weight_data);
  assign bias_ext = ACC_W'(bias_q[o_cnt]) <<< FRAC_BITS;
  // Arithmetic shift floors toward -inf; saturation then clamps to the word range.
  assign shifted  = acc >>> FRAC_BITS;

  always_comb begin
    sat_word = shifted[DATA_WIDTH-1:0];
    if (shifted > SAT_MAX)
      sat_word = SAT_MAX[DATA_WIDTH-1:0];
    else if (shifted < SAT_MIN)
      sat_word = SAT_MIN[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      weight_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      acc         <= '0;
      i_cnt       <= '0;
      o_cnt       <= '0;
      for (int k = 0; k < INPUT_NEURONS; k++)  in_q[k]   <= '0;
      for (int k = 0; k < OUTPUT_NEURONS; k++) bias_q[k] <= '0;
      for (int k = 0; k < OUTPUT_NEURONS; k++) out_q[k]  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (en) begin
            for (int k = 0; k < INPUT_NEURONS; k++)
              in_q[k] <= input_fc[DATA_WIDTH*k +: DATA_WIDTH];
            for (int k = 0; k < OUTPUT_NEURONS; k++)
              bias_q[k] <= bias[DATA_WIDTH*k +: DATA_WIDTH];
            i_cnt       <= '0;
            o_cnt       <= '0;
            busy        <= 1'b1;
            weight_addr <= '0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          // The address for weight 0 is already on the bus this cycle; the
          // ROM returns it during MAC cycle 0 while we present weight 1.
          acc   <= bias_ext;
          i_cnt <= '0;
          if (INPUT_NEURONS > 1)
            weight_addr <= weight_addr + ADDR_WIDTH'(1);
          state <= MAC;
        end
        MAC: begin
          acc <= acc + ACC_W'(product);
          if (i_cnt == I_LAST) begin
            state <= STORE;
          end else begin
            i_cnt <= i_cnt + IW'(1);
            // Stop at the neuron's last weight so the address never runs ahead.
            if (int'(i_cnt) < INPUT_NEURONS - 2)
              weight_addr <= weight_addr + ADDR_WIDTH'(1);
          end
        end
        STORE: begin
          out_q[o_cnt] <= sat_word;
          if (o_cnt == O_LAST) begin
            state <= DONE;
          end else begin
            o_cnt       <= o_cnt + OW'(1);
            weight_addr <= weight_addr + ADDR_WIDTH'(1);
            state       <= ISSUE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < OUTPUT_NEURONS; g++) begin : g_out
    assign output_fc[DATA_WIDTH*g +: DATA_WIDTH] = out_q[g];
  end

endmodule

// File: tb/tb_fc_layer_mac.sv
module tb_fc_layer_mac;

  localparam int DW = 32;
  localparam int FB = 16;
  localparam int NI = 4;
  localparam int NO = 2;
  localparam int AW = 11;
  localparam int RUN_EDGES = NO*(NI+2) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic [DW*NI-1:0]  input_fc;
  logic [DW*NO-1:0]  bias;
  logic [AW-1:0]     weight_addr;
  logic [DW-1:0]     weight_data;
  logic [DW*NO-1:0]  output_fc;
  logic              busy;
  logic              done;

  fc_layer_mac #(
    .DATA_WIDTH(DW), .FRAC_BITS(FB), .INPUT_NEURONS(NI),
    .OUTPUT_NEURONS(NO), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .input_fc(input_fc), .bias(bias),
    .weight_addr(weight_addr), .weight_data(weight_data),
    .output_fc(output_fc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // synchronous ROM, one cycle of read latency
  logic [DW-1:0] rom [NI*NO];
  always @(posedge clk)
    weight_data <= (weight_addr < AW'(NI*NO)) ? rom[weight_addr[2:0]] : '0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: plain wide arithmetic straight from the layer equation
  function automatic logic [DW*NO-1:0] fc_model(input logic [DW*NI-1:0] x,
                                                input logic [DW*NO-1:0] b);
    logic signed [127:0] acc;
    logic signed [127:0] r;
    logic [DW*NO-1:0]    res;
    res = '0;
    for (int o = 0; o < NO; o++) begin
      acc = $signed(b[DW*o +: DW]);
      acc = acc <<< FB;
      for (int i = 0; i < NI; i++)
        acc = acc + $signed(x[DW*i +: DW]) * $signed(rom[o*NI + i]);
      r = acc >>> FB;
      if (r > 128'sh7FFF_FFFF)       res[DW*o +: DW] = 32'h7FFF_FFFF;
      else if (r < -128'sh8000_0000) res[DW*o +: DW] = 32'h8000_0000;
      else                           res[DW*o +: DW] = r[DW-1:0];
    end
    return res;
  endfunction

  logic             m_valid = 1'b0;
  logic             m_run   = 1'b0;
  int               m_cnt   = 0;
  logic             exp_busy = 1'b0;
  logic             exp_done = 1'b0;
  logic [DW*NO-1:0] exp_out  = '0;
  logic [DW*NO-1:0] exp_pend = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_valid  = 1'b1;
      m_run    = 1'b0;
      m_cnt    = 0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_out  = '0;
    end else if (!m_run && en) begin
      m_run    = 1'b1;
      m_cnt    = 0;
      exp_pend = fc_model(input_fc, bias);
      exp_busy = 1'b1;
      exp_done = 1'b0;
    end else if (m_run) begin
      m_cnt++;
      exp_done = 1'b0;
      if (m_cnt == RUN_EDGES) begin
        m_run    = 1'b0;
        exp_busy = 1'b0;
        exp_done = 1'b1;
        exp_out  = exp_pend;
      end
    end else begin
      exp_done = 1'b0;
    end
  end

  logic [AW-1:0] addr_q [$];

  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", {63'd0, busy}, {63'd0, exp_busy});
      check("done", {63'd0, done}, {63'd0, exp_done});
      if (!m_run) check("output_fc", output_fc, exp_out);
      if (m_run) begin
        if (addr_q.size() == 0 || addr_q[$] != weight_addr)
          addr_q.push_back(weight_addr);
      end
      if (exp_done) begin
        check("addr_seq_len", 64'(addr_q.size()), 64'(NI*NO));
        for (int k = 0; k < addr_q.size() && k < NI*NO; k++)
          check("addr_seq", 64'(addr_q[k]), 64'(k));
      end
      if (!m_run) addr_q.delete();
    end
  end

  task automatic load(input logic [DW-1:0] x, input logic [DW-1:0] w,
                      input logic [DW-1:0] b0, input logic [DW-1:0] b1);
    for (int i = 0; i < NI; i++) input_fc[DW*i +: DW] = x;
    for (int k = 0; k < NI*NO; k++) rom[k] = w;
    bias = {b1, b0};
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 200) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_once(output int lat);
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
    wait_done(lat);
  endtask

  int lat;
  int k_done;
  int n;
  int cyc1, cyc2;

  initial begin
    reset = 1'b1; en = 1'b0; input_fc = '0; bias = '0;
    for (int k = 0; k < NI*NO; k++) rom[k] = '0;
    repeat (2) @(negedge clk);
    check("rst_output_fc", output_fc, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_weight_addr", 64'(weight_addr), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: 4 * (1.0 * 0.5) = 2.0
    load(32'h0001_0000, 32'h0000_8000, 32'h0, 32'h0);
    run_once(lat);
    check("t1_latency", 64'(lat), 64'd13);
    check("t1_out", output_fc, {32'h0002_0000, 32'h0002_0000});

    // 2: -4.0 and -4.0 + 0.5
    load(32'h0001_0000, 32'hFFFF_0000, 32'h0, 32'h0000_8000);
    run_once(lat);
    check("t2_out", output_fc, {32'hFFFC_8000, 32'hFFFC_0000});

    // 3: saturation both ways
    load(32'h7FFF_0000, 32'h7FFF_0000, 32'h0, 32'h0);
    run_once(lat);
    check("t3_pos_sat", output_fc, {32'h7FFF_FFFF, 32'h7FFF_FFFF});
    load(32'h7FFF_0000, 32'h8001_0000, 32'h0, 32'h0);
    run_once(lat);
    check("t3_neg_sat", output_fc, {32'h8000_0000, 32'h8000_0000});

    // 4: reset during neuron 1's MAC phase
    load(32'h0001_0000, 32'h0000_8000, 32'h0, 32'h0);
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t4_rst_out", output_fc, 64'd0);
    check("t4_rst_busy", {63'd0, busy}, 64'd0);
    check("t4_rst_done", {63'd0, done}, 64'd0);
    reset = 1'b0;
    load(32'h0001_0000, 32'hFFFF_0000, 32'h0, 32'h0000_8000);
    run_once(lat);
    check("t4_after_latency", 64'(lat), 64'd13);
    check("t4_after_out", output_fc, {32'hFFFC_8000, 32'hFFFC_0000});

    // 5a: en pulse while busy is ignored
    load(32'h0001_0000, 32'h0000_8000, 32'h0, 32'h0);
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    @(negedge clk); en = 1'b0;
    k_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) k_done++;
    end
    check("t5_single_done", 64'(k_done), 64'd1);

    // 5b: en held high gives back-to-back runs
    @(negedge clk); en = 1'b1;
    k_done = 0; n = 0; cyc1 = 0; cyc2 = 0;
    while (k_done < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (done) begin
        k_done++;
        if (k_done == 1) cyc1 = n; else cyc2 = n;
      end
    end
    en = 1'b0;
    check("t5_two_dones", 64'(k_done), 64'd2);
    check("t5_spacing", 64'(cyc2 - cyc1), 64'd14);
    repeat (3) @(negedge clk);

    // 6: inputs changed after start have no effect
    load(32'h0001_0000, 32'h0000_8000, 32'h0, 32'h0);
    @(negedge clk); en = 1'b1;
    @(negedge clk); en = 1'b0;
    for (int i = 0; i < NI; i++) input_fc[DW*i +: DW] = 32'h1234_5678;
    bias = {32'h0100_0000, 32'h0100_0000};
    wait_done(lat);
    check("t6_latched_out", output_fc, {32'h0002_0000, 32'h0002_0000});
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
